// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, LSU and memory-side signals of the
// unified memory port arbiter. The arbiter connects through the slave
// modport; the core/memory environment uses the master modport.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4
);
    // instruction fetch side
    logic                       inst_req;
    logic [DATA_WIDTH-1:0]      inst_addr;
    logic                       inst_valid;
    logic [DATA_WIDTH-1:0]      inst_data;
    // LSU side
    logic                       data_req;
    logic                       data_we;
    logic [BYTE_DATA_WIDTH-1:0] byte_enable;
    logic [DATA_WIDTH-1:0]      data_addr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic                       data_valid;
    logic [DATA_WIDTH-1:0]      rdata;
    // memory side
    logic                       mem_req;
    logic                       mem_we;
    logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable;
    logic [DATA_WIDTH-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic                       mem_valid;
    logic [DATA_WIDTH-1:0]      mem_rdata;
    // status
    logic                       busy;

    modport slave (
        input  inst_req, inst_addr, data_req, data_we, byte_enable, data_addr, wdata,
               mem_valid, mem_rdata,
        output inst_valid, inst_data, data_valid, rdata,
               mem_req, mem_we, mem_byte_enable, mem_addr, mem_wdata, busy
    );

    modport master (
        output inst_req, inst_addr, data_req, data_we, byte_enable, data_addr, wdata,
               mem_valid, mem_rdata,
        input  inst_valid, inst_data, data_valid, rdata,
               mem_req, mem_we, mem_byte_enable, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and the LSU.
// Data requests win by default; a starvation counter forces an instruction
// grant after STARVE_LIMIT consecutive data grants taken while fetch waits.
// Optional feature macro: MEM_ARB_PERF_EN adds saturating 32-bit grant and
// wait-cycle performance counters.
module mem_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]         perf_inst_grants,
    output logic [31:0]         perf_data_grants,
    output logic [31:0]         perf_wait_cycles,
`endif
    mem_arbiter_if.slave        bus
);
    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } state_e;

    state_e                     state_q;
    logic [CNT_W-1:0]           starve_cnt_q;
    logic                       mem_req_q;
    logic                       mem_we_q;
    logic [BYTE_DATA_WIDTH-1:0] mem_be_q;
    logic [DATA_WIDTH-1:0]      mem_addr_q;
    logic [DATA_WIDTH-1:0]      mem_wdata_q;

    logic                       grant_d_s;
    logic                       grant_i_s;
    logic                       inst_valid_s;
    logic                       data_valid_s;

    // Grant decision for the IDLE cycle and owner-qualified completion pulses
    // (a completion coinciding with reset is dropped).
    always_comb begin
        grant_d_s    = 1'b0;
        grant_i_s    = 1'b0;
        inst_valid_s = 1'b0;
        data_valid_s = 1'b0;
        if (state_q == IDLE) begin
            if (bus.data_req && (!bus.inst_req || (starve_cnt_q < LIMIT))) begin
                grant_d_s = 1'b1;
            end else if (bus.inst_req) begin
                grant_i_s = 1'b1;
            end else begin
                grant_d_s = 1'b0;
            end
        end else begin
            inst_valid_s = (state_q == GNT_I) && bus.mem_valid && !rst;
            data_valid_s = (state_q == GNT_D) && bus.mem_valid && !rst;
        end
    end

    // Arbiter FSM: latches the owner's request on the grant edge and holds the
    // memory outputs stable until the memory completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= {CNT_W{1'b0}};
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= {BYTE_DATA_WIDTH{1'b0}};
            mem_addr_q   <= {DATA_WIDTH{1'b0}};
            mem_wdata_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d_s) begin
                        state_q      <= GNT_D;
                        starve_cnt_q <= bus.inst_req ? (starve_cnt_q + CNT_W'(1)) : {CNT_W{1'b0}};
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= bus.data_we;
                        mem_be_q     <= bus.byte_enable;
                        mem_addr_q   <= bus.data_addr;
                        mem_wdata_q  <= bus.wdata;
                    end else if (grant_i_s) begin
                        state_q      <= GNT_I;
                        starve_cnt_q <= {CNT_W{1'b0}};
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_be_q     <= {BYTE_DATA_WIDTH{1'b1}};
                        mem_addr_q   <= bus.inst_addr;
                        mem_wdata_q  <= {DATA_WIDTH{1'b0}};
                    end else begin
                        state_q      <= IDLE;
                    end
                end
                GNT_D, GNT_I: begin
                    if (bus.mem_valid) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= {BYTE_DATA_WIDTH{1'b0}};
                        mem_addr_q  <= {DATA_WIDTH{1'b0}};
                        mem_wdata_q <= {DATA_WIDTH{1'b0}};
                    end else begin
                        state_q     <= state_q;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_req_q   <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_be_q    <= {BYTE_DATA_WIDTH{1'b0}};
                    mem_addr_q  <= {DATA_WIDTH{1'b0}};
                    mem_wdata_q <= {DATA_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign bus.mem_req         = mem_req_q;
    assign bus.busy            = mem_req_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_byte_enable = mem_be_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;
    assign bus.inst_valid      = inst_valid_s;
    assign bus.data_valid      = data_valid_s;
    assign bus.inst_data       = inst_valid_s ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
    assign bus.rdata           = data_valid_s ? bus.mem_rdata : {DATA_WIDTH{1'b0}};

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_inst_q;
    logic [31:0] perf_data_q;
    logic [31:0] perf_wait_q;
    logic        wait_s;

    // A requester is waiting whenever it asserts req but does not own the port.
    assign wait_s = ((state_q != GNT_I) && bus.inst_req) || ((state_q != GNT_D) && bus.data_req);

    // Saturating grant and wait-cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_q <= 32'h0000_0000;
            perf_data_q <= 32'h0000_0000;
            perf_wait_q <= 32'h0000_0000;
        end else begin
            if (grant_i_s && (perf_inst_q != 32'hFFFF_FFFF)) begin
                perf_inst_q <= perf_inst_q + 32'd1;
            end
            if (grant_d_s && (perf_data_q != 32'hFFFF_FFFF)) begin
                perf_data_q <= perf_data_q + 32'd1;
            end
            if (wait_s && (perf_wait_q != 32'hFFFF_FFFF)) begin
                perf_wait_q <= perf_wait_q + 32'd1;
            end
        end
    end

    assign perf_inst_grants = perf_inst_q;
    assign perf_data_grants = perf_data_q;
    assign perf_wait_cycles = perf_wait_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter. Inputs change 2 time
// units after the rising edge; outputs are sampled 1 unit later.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   vec_cnt;
    int   miscompares;
    logic exp_d;

    mem_arbiter_if #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_inst_grants;
    logic [31:0] perf_data_grants;
    logic [31:0] perf_wait_cycles;
`endif

    mem_arbiter #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4), .STARVE_LIMIT(4)) dut (
        .clk              (clk),
        .rst              (rst),
`ifdef MEM_ARB_PERF_EN
        .perf_inst_grants (perf_inst_grants),
        .perf_data_grants (perf_data_grants),
        .perf_wait_cycles (perf_wait_cycles),
`endif
        .bus              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        vec_cnt = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.inst_req = 1'b0;     bus.inst_addr = 32'h0;
        bus.data_req = 1'b0;     bus.data_we = 1'b0;
        bus.byte_enable = 4'h0;  bus.data_addr = 32'h0;
        bus.wdata = 32'h0;       bus.mem_valid = 1'b0;
        bus.mem_rdata = 32'h0;

        // reset state
        cyc(); cyc(); #1;
        chk("rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
        chk("rst_busy",     {31'd0, bus.busy}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_ivalid",   {31'd0, bus.inst_valid}, 32'd0);
        rst = 1'b0;

        // 1: single fetch
        cyc(); bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_0100; #1;
        chk("t1_c1_mem_req", {31'd0, bus.mem_req}, 32'd0);
        cyc(); #1;
        chk("t1_c2_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("t1_c2_addr",    bus.mem_addr, 32'h0000_0100);
        chk("t1_c2_we",      {31'd0, bus.mem_we}, 32'd0);
        chk("t1_c2_be",      {28'd0, bus.mem_byte_enable}, 32'hF);
        chk("t1_c2_busy",    {31'd0, bus.busy}, 32'd1);
        cyc(); bus.mem_rdata = 32'h0000_0055; #1;
        chk("t1_c3_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("t1_c3_idata",   bus.inst_data, 32'd0);
        chk("t1_c3_ivalid",  {31'd0, bus.inst_valid}, 32'd0);
        cyc(); bus.mem_valid = 1'b1; bus.mem_rdata = 32'h0000_0013; #1;
        chk("t1_c4_ivalid",  {31'd0, bus.inst_valid}, 32'd1);
        chk("t1_c4_idata",   bus.inst_data, 32'h0000_0013);
        chk("t1_c4_dvalid",  {31'd0, bus.data_valid}, 32'd0);
        chk("t1_c4_rdata",   bus.rdata, 32'd0);
        cyc(); bus.inst_req = 1'b0; bus.mem_valid = 1'b0; bus.mem_rdata = 32'h0; #1;
        chk("t1_c5_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("t1_c5_ivalid",  {31'd0, bus.inst_valid}, 32'd0);
        chk("t1_c5_addr",    bus.mem_addr, 32'd0);

        // 2: simultaneous requests, data store first
        cyc();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_0104;
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.byte_enable = 4'b0011;
        bus.data_addr = 32'h0000_2000; bus.wdata = 32'hDEAD_BEEF; #1;
        chk("t2_c1_mem_req", {31'd0, bus.mem_req}, 32'd0);
        cyc(); #1;
        chk("t2_c2_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("t2_c2_we",      {31'd0, bus.mem_we}, 32'd1);
        chk("t2_c2_be",      {28'd0, bus.mem_byte_enable}, 32'h3);
        chk("t2_c2_addr",    bus.mem_addr, 32'h0000_2000);
        chk("t2_c2_wdata",   bus.mem_wdata, 32'hDEAD_BEEF);
        cyc(); bus.mem_valid = 1'b1; bus.mem_rdata = 32'hAAAA_5555; #1;
        chk("t2_c3_dvalid",  {31'd0, bus.data_valid}, 32'd1);
        chk("t2_c3_ivalid",  {31'd0, bus.inst_valid}, 32'd0);
        chk("t2_c3_rdata",   bus.rdata, 32'hAAAA_5555);
        chk("t2_c3_idata",   bus.inst_data, 32'd0);
        cyc(); bus.data_req = 1'b0; bus.data_we = 1'b0; bus.mem_valid = 1'b0; #1;
        chk("t2_c4_bubble",  {31'd0, bus.mem_req}, 32'd0);
        cyc(); #1;
        chk("t2_c5_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("t2_c5_addr",    bus.mem_addr, 32'h0000_0104);
        chk("t2_c5_we",      {31'd0, bus.mem_we}, 32'd0);
        chk("t2_c5_be",      {28'd0, bus.mem_byte_enable}, 32'hF);
        cyc(); bus.mem_valid = 1'b1; bus.mem_rdata = 32'h0000_0093; #1;
        chk("t2_c6_ivalid",  {31'd0, bus.inst_valid}, 32'd1);
        chk("t2_c6_idata",   bus.inst_data, 32'h0000_0093);
        chk("t2_c6_dvalid",  {31'd0, bus.data_valid}, 32'd0);
        cyc(); bus.inst_req = 1'b0; bus.mem_valid = 1'b0; #1;
        chk("t2_c7_mem_req", {31'd0, bus.mem_req}, 32'd0);

        // 4: reset mid-transaction, mem_valid together with rst is discarded
        cyc(); bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_0200; #1;
        cyc(); #1;
        chk("t4_c2_mem_req", {31'd0, bus.mem_req}, 32'd1);
        cyc(); rst = 1'b1; bus.mem_valid = 1'b1; bus.mem_rdata = 32'h0000_0077; #1;
        chk("t4_c3_ivalid",  {31'd0, bus.inst_valid}, 32'd0);
        chk("t4_c3_idata",   bus.inst_data, 32'd0);
        cyc(); rst = 1'b0; bus.inst_req = 1'b0; bus.mem_valid = 1'b0; #1;
        chk("t4_c4_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("t4_c4_busy",    {31'd0, bus.busy}, 32'd0);
        cyc(); bus.mem_valid = 1'b1; #1;
        chk("t4_c5_ivalid",  {31'd0, bus.inst_valid}, 32'd0);
        chk("t4_c5_dvalid",  {31'd0, bus.data_valid}, 32'd0);
        cyc(); bus.mem_valid = 1'b0; #1;
        chk("t4_c6_mem_req", {31'd0, bus.mem_req}, 32'd0);

        // 5: spurious mem_valid in IDLE
        cyc(); bus.mem_valid = 1'b1; bus.mem_rdata = 32'h0000_1234; #1;
        chk("t5_ivalid",     {31'd0, bus.inst_valid}, 32'd0);
        chk("t5_dvalid",     {31'd0, bus.data_valid}, 32'd0);
        chk("t5_busy",       {31'd0, bus.busy}, 32'd0);
        chk("t5_rdata",      bus.rdata, 32'd0);
        cyc(); bus.mem_valid = 1'b0; #1;
        chk("t5_mem_req",    {31'd0, bus.mem_req}, 32'd0);

        // 7: requester drops req mid-transaction; new request during completion
        cyc(); bus.data_req = 1'b1; bus.data_we = 1'b0; bus.byte_enable = 4'hF;
        bus.data_addr = 32'h0000_3000; #1;
        cyc(); bus.data_req = 1'b0; #1;
        chk("t7_c2_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("t7_c2_addr",    bus.mem_addr, 32'h0000_3000);
        cyc(); bus.mem_valid = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_0400; #1;
        chk("t7_c3_dvalid",  {31'd0, bus.data_valid}, 32'd1);
        chk("t7_c3_rdata",   bus.rdata, 32'hCAFE_0001);
        cyc(); bus.mem_valid = 1'b0; #1;
        chk("t7_c4_mem_req", {31'd0, bus.mem_req}, 32'd0);
        cyc(); #1;
        chk("t7_c5_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("t7_c5_addr",    bus.mem_addr, 32'h0000_0400);
        cyc(); bus.mem_valid = 1'b1; bus.mem_rdata = 32'h0000_0033; #1;
        chk("t7_c6_ivalid",  {31'd0, bus.inst_valid}, 32'd1);
        cyc(); bus.inst_req = 1'b0; bus.mem_valid = 1'b0; #1;

        // 3/6: starvation limiter after a fresh reset
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_d = ((k % 5) != 4);
            cyc();
            bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_0600;
            bus.data_req = 1'b1; bus.data_addr = 32'h0000_0700; bus.data_we = 1'b0;
            bus.mem_valid = 1'b0; #1;
            chk("t3_idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
            cyc(); bus.mem_valid = 1'b1; bus.mem_rdata = 32'(k); #1;
            chk("t3_dvalid", {31'd0, bus.data_valid}, {31'd0, exp_d});
            chk("t3_ivalid", {31'd0, bus.inst_valid}, {31'd0, ~exp_d});
            chk("t3_addr",   bus.mem_addr, exp_d ? 32'h0000_0700 : 32'h0000_0600);
        end
        cyc(); bus.mem_valid = 1'b0; bus.inst_req = 1'b0; bus.data_req = 1'b0; #1;
        chk("t3_end_mem_req", {31'd0, bus.mem_req}, 32'd0);
`ifdef MEM_ARB_PERF_EN
        chk("t6_data_grants", perf_data_grants, 32'd8);
        chk("t6_inst_grants", perf_inst_grants, 32'd2);
        chk("t6_wait_nonzero", {31'd0, (perf_wait_cycles != 32'd0)}, 32'd1);
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; #1;
        chk("t6_rst_data", perf_data_grants, 32'd0);
        chk("t6_rst_inst", perf_inst_grants, 32'd0);
        chk("t6_rst_wait", perf_wait_cycles, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end
endmodule
